// File: rtl/gcm_dec_release.sv
// Purpose: holds GCM-decrypted plaintext until the local tag matches the received tag, then releases it.
// Latency: auth pulse two cycles after both tags are present; the first block is presented with auth_ok.
// Backpressure: valid/ready on pt_out holds data stable; the input side has no ready and overflows past DEPTH.
module gcm_dec_release #(
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] pt_in_data,
   input  logic         pt_in_valid,
   input  logic         pt_in_last,
   input  logic [127:0] calc_tag,
   input  logic         calc_tag_valid,
   input  logic [127:0] rx_tag,
   input  logic         rx_tag_valid,
   output logic [127:0] pt_out_data,
   output logic         pt_out_valid,
   output logic         pt_out_last,
   input  logic         pt_out_ready,
   output logic         auth_ok,
   output logic         auth_fail,
   output logic         err_len,
   output logic         busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] TWO  = CW'(2);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_WAIT_TAG, S_CHECK, S_RELEASE, S_DISCARD
   } state_t;

   state_t        state;
   logic [127:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic [CW-1:0] count;
   logic [127:0]  calc_tag_q;
   logic [127:0]  rx_tag_q;
   logic          calc_seen;
   logic          rx_seen;
   logic          tag_window;
   logic          wr_en;
   logic          xfer;
   logic          mismatch;

   // A start in the same cycle overrides every other input, including tag strobes.
   assign tag_window = (state == S_COLLECT || state == S_WAIT_TAG) && !start;
   assign wr_en      = rst_n && (state == S_COLLECT) && !start && pt_in_valid && (count != FULL);
   assign xfer       = (state == S_RELEASE) && pt_out_valid && pt_out_ready;
   assign rd_nxt     = rd_ptr + 1'b1;
   // Full-width reduction: no early exit, so timing is independent of where the tags differ.
   assign mismatch   = |(calc_tag_q ^ rx_tag_q);
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= pt_in_data;
      if (rst_n && tag_window && calc_tag_valid)
         calc_tag_q <= calc_tag;
      if (rst_n && tag_window && rx_tag_valid)
         rx_tag_q <= rx_tag;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         calc_seen    <= 1'b0;
         rx_seen      <= 1'b0;
         pt_out_data  <= '0;
         pt_out_valid <= 1'b0;
         pt_out_last  <= 1'b0;
         auth_ok      <= 1'b0;
         auth_fail    <= 1'b0;
         err_len      <= 1'b0;
      end else begin
         auth_ok   <= 1'b0;
         auth_fail <= 1'b0;
         err_len   <= 1'b0;
         if (tag_window && calc_tag_valid)
            calc_seen <= 1'b1;
         if (tag_window && rx_tag_valid)
            rx_seen <= 1'b1;

         if (start) begin
            state        <= S_COLLECT;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            calc_seen    <= 1'b0;
            rx_seen      <= 1'b0;
            pt_out_valid <= 1'b0;
            pt_out_last  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  wr_ptr    <= '0;
                  rd_ptr    <= '0;
                  count     <= '0;
                  calc_seen <= 1'b0;
                  rx_seen   <= 1'b0;
               end
               S_COLLECT: begin
                  if (pt_in_valid) begin
                     if (count == FULL) begin
                        err_len <= 1'b1;
                        state   <= S_DISCARD;
                     end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + ONE;
                        if (pt_in_last)
                           state <= S_WAIT_TAG;
                     end
                  end else if (pt_in_last) begin
                     state <= S_WAIT_TAG;
                  end
               end
               S_WAIT_TAG: begin
                  if (calc_seen && rx_seen)
                     state <= S_CHECK;
               end
               S_CHECK: begin
                  if (mismatch) begin
                     auth_fail <= 1'b1;
                     state     <= S_DISCARD;
                  end else begin
                     auth_ok <= 1'b1;
                     if (count != '0) begin
                        state        <= S_RELEASE;
                        pt_out_valid <= 1'b1;
                        pt_out_data  <= mem[rd_ptr];
                        pt_out_last  <= (count == ONE);
                     end else begin
                        state <= S_IDLE;
                     end
                  end
               end
               S_RELEASE: begin
                  // Prefetch the next block on each transfer to sustain one block per cycle.
                  if (xfer) begin
                     rd_ptr <= rd_nxt;
                     count  <= count - ONE;
                     if (count == ONE) begin
                        pt_out_valid <= 1'b0;
                        pt_out_last  <= 1'b0;
                        state        <= S_IDLE;
                     end else begin
                        pt_out_data <= mem[rd_nxt];
                        pt_out_last <= (count == TWO);
                     end
                  end
               end
               S_DISCARD: begin
                  wr_ptr    <= '0;
                  rd_ptr    <= '0;
                  count     <= '0;
                  calc_seen <= 1'b0;
                  rx_seen   <= 1'b0;
                  state     <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gcm_dec_release.sv
// Scoreboard bench for gcm_dec_release: directed NIST-style messages followed by randomized messages.
module tb_gcm_dec_release;
   localparam int DEPTH = 4;
   localparam logic [127:0] TAG1 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
   localparam logic [127:0] TAG2 = 128'hab6e47d42cec13bdf53a67b21257bddf;
   localparam logic [127:0] TAG3 = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, start, pt_in_valid, pt_in_last, calc_tag_valid, rx_tag_valid, pt_out_ready;
   logic [127:0] pt_in_data, calc_tag, rx_tag, pt_out_data;
   logic         pt_out_valid, pt_out_last, auth_ok, auth_fail, err_len, busy;

   gcm_dec_release #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .pt_in_data(pt_in_data), .pt_in_valid(pt_in_valid), .pt_in_last(pt_in_last),
      .calc_tag(calc_tag), .calc_tag_valid(calc_tag_valid),
      .rx_tag(rx_tag), .rx_tag_valid(rx_tag_valid),
      .pt_out_data(pt_out_data), .pt_out_valid(pt_out_valid), .pt_out_last(pt_out_last),
      .pt_out_ready(pt_out_ready),
      .auth_ok(auth_ok), .auth_fail(auth_fail), .err_len(err_len), .busy(busy)
   );

   int checks = 0;
   int errors = 0;
   logic [128:0] exp_blk[$];   // {last, data}
   int           exp_ev[$];    // 1 auth_ok, 2 auth_fail, 3 err_len
   int           ready_mode = 0;
   logic         ready_man = 1'b1;

   logic [127:0] tc3 [4];
   initial begin
      tc3[0] = 128'hd9313225f88406e5a55909c5aff5269a;
      tc3[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
      tc3[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
      tc3[3] = 128'hb16aedf5aa0de657ba637b391aafd255;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Ready driver: constant 1, random, or manual pattern from the main thread.
   initial begin
      pt_out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       pt_out_ready = 1'b1;
            1:       pt_out_ready = 1'($urandom_range(0, 1));
            default: pt_out_ready = ready_man;
         endcase
      end
   end

   // Monitor: pops expectations whenever the DUT presents a transfer or a status pulse.
   logic         stall_q = 1'b0;
   logic [127:0] stall_dat;
   logic         stall_last;
   logic [128:0] e;
   int           got;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (stall_q) begin
               check("hold_valid", 128'(pt_out_valid), 128'(1));
               check("hold_data", pt_out_data, stall_dat);
               check("hold_last", 128'(pt_out_last), 128'(stall_last));
            end
            if (pt_out_valid && exp_blk.size() == 0) begin
               check("unexpected_valid", 128'(pt_out_valid), 128'(0));
            end else if (pt_out_valid && pt_out_ready) begin
               e = exp_blk.pop_front();
               check("out_data", pt_out_data, e[127:0]);
               check("out_last", 128'(pt_out_last), 128'(e[128]));
            end
            if (auth_ok || auth_fail || err_len) begin
               got = auth_ok ? 1 : (auth_fail ? 2 : 3);
               check("pulse_onehot", 128'(int'(auth_ok) + int'(auth_fail) + int'(err_len)), 128'(1));
               if (exp_ev.size() == 0)
                  check("unexpected_pulse", 128'(got), 128'(0));
               else
                  check("pulse_kind", 128'(got), 128'(exp_ev.pop_front()));
            end
            stall_q    = pt_out_valid && !pt_out_ready && !start;
            stall_dat  = pt_out_data;
            stall_last = pt_out_last;
         end else begin
            stall_q = 1'b0;
         end
      end
   end

   task automatic slot(input logic v, input logic l, input logic [127:0] d,
                       input logic cv, input logic [127:0] ct, input logic rv, input logic [127:0] rt);
      pt_in_valid = v; pt_in_last = l; pt_in_data = d;
      calc_tag_valid = cv; calc_tag = ct; rx_tag_valid = rv; rx_tag = rt;
      @(posedge clk);
      #1;
      pt_in_valid = 1'b0; pt_in_last = 1'b0; calc_tag_valid = 1'b0; rx_tag_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts negedges until an auth pulse; 3 means the pulse came at T+2.
   task automatic wait_pulse(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(auth_ok || auth_fail) && n < 40);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 300);
      check("reach_idle", 128'(busy), 128'(0));
   endtask

   int           lat, n, cyc, cpos, rpos;
   bit           match, sep_last;
   logic [127:0] ct, rt, blk [6];

   initial begin
      #600000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; pt_in_valid = 1'b0; pt_in_last = 1'b0; pt_in_data = '0;
      calc_tag = '0; calc_tag_valid = 1'b0; rx_tag = '0; rx_tag_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 128'(pt_out_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_pulses", 128'({auth_ok, auth_fail, err_len, pt_out_last}), 128'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;

      // NIST TC2: one zero block.
      exp_ev.push_back(1);
      exp_blk.push_back({1'b1, 128'h0});
      do_start();
      check("start_busy", 128'(busy), 128'(1));
      slot(1, 1, 128'h0, 1, TAG2, 1, TAG2);
      wait_pulse(lat);
      check("tc2_latency", 128'(lat), 128'(3));
      check("tc2_valid", 128'(pt_out_valid), 128'(1));
      @(negedge clk);
      check("tc2_busy_fall", 128'(busy), 128'(0));

      // NIST TC3: four blocks with ready toggling 1,0,1,0...
      ready_man = 1'b1;
      ready_mode = 2;
      exp_ev.push_back(1);
      for (int i = 0; i < 4; i++) exp_blk.push_back({i == 3, tc3[i]});
      do_start();
      for (int i = 0; i < 4; i++) slot(1, i == 3, tc3[i], i == 3, TAG3, i == 3, TAG3);
      wait_pulse(lat);
      check("tc3_latency", 128'(lat), 128'(3));
      check("tc3_valid", 128'(pt_out_valid), 128'(1));
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1 ready_man = (k % 2 == 0);
      end
      @(negedge clk);
      @(negedge clk);
      check("tc3_busy_fall", 128'(busy), 128'(0));
      check("tc3_drained", 128'(exp_blk.size()), 128'(0));
      ready_mode = 0;

      // Tag mismatch on TC3: rx_tag bit 0 flipped.
      exp_ev.push_back(2);
      do_start();
      for (int i = 0; i < 4; i++) slot(1, i == 3, tc3[i], i == 3, TAG3, i == 3, TAG3 ^ 128'h1);
      wait_pulse(lat);
      check("fail_latency", 128'(lat), 128'(3));
      check("fail_no_valid", 128'(pt_out_valid), 128'(0));
      @(negedge clk);
      check("fail_busy_fall", 128'(busy), 128'(0));

      // Next message after a failure still passes.
      ct = rnd128();
      exp_ev.push_back(1);
      exp_blk.push_back({1'b1, ct});
      do_start();
      slot(1, 1, ct, 1, TAG2, 1, TAG2);
      wait_idle();

      // NIST TC1: empty message.
      exp_ev.push_back(1);
      do_start();
      slot(0, 1, 128'h0, 1, TAG1, 1, TAG1);
      wait_pulse(lat);
      check("tc1_latency", 128'(lat), 128'(3));
      check("tc1_idle", 128'(busy), 128'(0));
      check("tc1_no_valid", 128'(pt_out_valid), 128'(0));

      // Overflow: five blocks into a four-block buffer.
      exp_ev.push_back(3);
      do_start();
      for (int i = 0; i < 5; i++) slot(1, 0, rnd128(), 0, '0, 0, '0);
      @(negedge clk);
      check("ovf_err_len", 128'(err_len), 128'(1));
      @(negedge clk);
      check("ovf_idle", 128'(busy), 128'(0));

      // Abort during release after one transfer, then a two-block message.
      ready_man = 1'b1;
      ready_mode = 2;
      exp_ev.push_back(1);
      for (int i = 0; i < 4; i++) exp_blk.push_back({i == 3, tc3[i]});
      do_start();
      for (int i = 0; i < 4; i++) slot(1, i == 3, tc3[i], i == 3, TAG3, i == 3, TAG3);
      wait_pulse(lat);
      @(posedge clk);
      #1;
      start = 1'b1;
      ready_man = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp_blk.delete();
      @(negedge clk);
      check("abort_valid_drop", 128'(pt_out_valid), 128'(0));
      check("abort_collect", 128'(busy), 128'(1));
      ready_man = 1'b1;
      exp_ev.push_back(1);
      blk[0] = rnd128();
      blk[1] = rnd128();
      exp_blk.push_back({1'b0, blk[0]});
      exp_blk.push_back({1'b1, blk[1]});
      slot(1, 0, blk[0], 0, '0, 0, '0);
      slot(1, 1, blk[1], 1, TAG3, 1, TAG3);
      wait_idle();
      check("abort_two_blocks", 128'(exp_blk.size()), 128'(0));
      ready_mode = 0;

      // Tags before last, rx_tag strobed twice with the second value matching.
      exp_ev.push_back(1);
      for (int i = 0; i < 3; i++) begin
         blk[i] = rnd128();
         exp_blk.push_back({i == 2, blk[i]});
      end
      do_start();
      slot(1, 0, blk[0], 1, TAG2, 0, '0);
      slot(0, 0, '0, 0, '0, 1, TAG1);
      slot(1, 0, blk[1], 0, '0, 1, TAG2);
      slot(1, 1, blk[2], 0, '0, 0, '0);
      wait_pulse(lat);
      check("early_tag_latency", 128'(lat), 128'(3));
      wait_idle();

      // Reset in the middle of collection.
      do_start();
      slot(1, 0, rnd128(), 1, TAG2, 0, '0);
      slot(1, 0, rnd128(), 0, '0, 0, '0);
      rst_n = 1'b0;
      slot(1, 0, rnd128(), 0, '0, 1, TAG2);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_busy", 128'(busy), 128'(0));
      check("midrst_flags", 128'({pt_out_valid, pt_out_last, auth_ok, auth_fail, err_len}), 128'(0));
      check("midrst_data", pt_out_data, 128'h0);

      // Randomized messages against the reference rules.
      ready_mode = 1;
      for (int m = 0; m < 40; m++) begin
         n = $urandom_range(0, DEPTH + 1);
         match = ($urandom_range(0, 2) != 0);
         ct = rnd128();
         rt = match ? ct : (ct ^ (128'h1 << $urandom_range(0, 127)));
         for (int i = 0; i < n; i++) blk[i] = rnd128();
         if (n > DEPTH) begin
            exp_ev.push_back(3);
         end else begin
            exp_ev.push_back(match ? 1 : 2);
            if (match)
               for (int i = 0; i < n; i++) exp_blk.push_back({i == n - 1, blk[i]});
         end
         do_start();
         if (n > DEPTH) begin
            for (int i = 0; i < n; i++) slot(1, 0, blk[i], 0, '0, 0, '0);
         end else begin
            sep_last = (n == 0) || ($urandom_range(0, 1) == 1);
            cpos = $urandom_range(0, n + 2);
            rpos = $urandom_range(0, n + 2);
            cyc = 0;
            for (int i = 0; i < n; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  slot(0, 0, '0, cyc == cpos, ct, cyc == rpos, rt);
                  cyc++;
               end
               slot(1, !sep_last && (i == n - 1), blk[i], cyc == cpos, ct, cyc == rpos, rt);
               cyc++;
            end
            if (sep_last) begin
               slot(0, 1, '0, cyc == cpos, ct, cyc == rpos, rt);
               cyc++;
            end
            while (cyc <= cpos || cyc <= rpos) begin
               slot(0, 0, '0, cyc == cpos, ct, cyc == rpos, rt);
               cyc++;
            end
         end
         wait_idle();
      end

      ready_mode = 0;
      repeat (5) @(negedge clk);
      check("events_drained", 128'(exp_ev.size()), 128'(0));
      check("blocks_drained", 128'(exp_blk.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
